uart_tx_serializer: RTL and testbench

- Downstream neighbour of the PicoBlaze output-port decoder.
- Consumes the registered 8-bit transmit byte and a one-cycle write strobe from the decoder, and serialises each byte as an 8N1 (or 8N2) UART frame on the tx pin.
- A one-entry holding register decouples processor writes from the frame in flight, so the next byte follows the current stop bit with no gap.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_bit_timer.sv | 39 +++
 rtl/uart_tx_serializer.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit serializer and the future receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and flags the last cycle.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = (cnt_q == LAST) && !clear;

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1/8N2 UART transmitter with a one-entry holding register for gapless back-to-back frames.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_input,
  input  logic       tx_wr,
  input  logic       clear_overrun,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_full,
  output logic       tx_done_tick,
  output logic       overrun
);

  localparam int                 IW        = $clog2(DATA_BITS);
  localparam logic [IW-1:0]      LAST_IDX  = IW'(DATA_BITS - 1);
  localparam logic               STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_valid_q, hold_valid_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 overrun_q, overrun_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_end_s, stop_last_s, load_s, timer_clear_s;

  // Timer is held at zero while idle so a new frame always starts on a full bit period.
  assign timer_clear_s = (state_q == IDLE);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear_s),
    .bit_end(bit_end_s)
  );

  assign stop_last_s = (state_q == STOP) && bit_end_s && (stop_cnt_q == STOP_LAST);
  assign load_s      = hold_valid_q && ((state_q == IDLE) || stop_last_s);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    case (state_q)
      IDLE: begin
        if (hold_valid_q) begin
          state_d = START;
          shift_d = hold_q;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + IW'(1);
          if (bit_idx_q == LAST_IDX) begin
            state_d    = STOP;
            stop_cnt_d = 1'b0;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (stop_last_s) begin
          if (hold_valid_q) begin
            state_d = START;
            shift_d = hold_q;
          end else begin
            state_d = IDLE;
          end
        end else if (bit_end_s) begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end else begin
          state_d = STOP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Unload wins over capture; a write seen while full is dropped and flagged (set beats clear).
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    overrun_d    = overrun_q;
    if (load_s) begin
      hold_valid_d = 1'b0;
    end else if (tx_wr && !hold_valid_q) begin
      hold_d       = tx_input;
      hold_valid_d = 1'b1;
    end else begin
      hold_valid_d = hold_valid_q;
    end
    if (tx_wr && hold_valid_q) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != IDLE);
    done_d = stop_last_s;
    case (state_q)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      bit_idx_q    <= '0;
      stop_cnt_q   <= 1'b0;
      overrun_q    <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      bit_idx_q    <= bit_idx_d;
      stop_cnt_q   <= stop_cnt_d;
      overrun_q    <= overrun_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_full      = hold_valid_q;
  assign tx_done_tick = done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at 4 clocks/bit: one instance with 1 stop bit, one with 2.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din_a, din_b;
  logic       wr_a, wr_b, clr_a, clr_b;
  logic       tx_a, busy_a, full_a, done_a, ovr_a;
  logic       tx_b, busy_b, full_b, done_b, ovr_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .tx_input(din_a), .tx_wr(wr_a), .clear_overrun(clr_a),
    .tx(tx_a), .tx_busy(busy_a), .tx_full(full_a), .tx_done_tick(done_a), .overrun(ovr_a)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .tx_input(din_b), .tx_wr(wr_b), .clear_overrun(clr_b),
    .tx(tx_b), .tx_busy(busy_b), .tx_full(full_b), .tx_done_tick(done_b), .overrun(ovr_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level in frame slot k: start, 8 data bits LSB first, then stop.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
    else return 1'b1;
  endfunction

  initial begin
    int bad, ndone, dpos, d1, d2;
    reset = 1'b1;
    din_a = 8'h00; din_b = 8'h00;
    wr_a = 1'b0; wr_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;

    // Reset state
    repeat (3) begin
      tick();
      check_eq("rst_tx", tx_a, 1);
      check_eq("rst_busy", busy_a, 0);
      check_eq("rst_full", full_a, 0);
      check_eq("rst_ovr", ovr_a, 0);
    end
    reset = 1'b0;
    tick();
    check_eq("post_rst_tx", tx_a, 1);
    check_eq("post_rst_busy", busy_a, 0);
    check_eq("post_rst_done", done_a, 0);
    bad = 0;
    repeat (20) begin
      tick();
      if (tx_a !== 1'b1) bad++;
    end
    check_eq("idle_tx_low_cycles", bad, 0);

    // Single byte 0x55
    din_a = 8'h55; wr_a = 1'b1;
    tick();
    wr_a = 1'b0;
    check_eq("s_full_e0", full_a, 1);
    check_eq("s_tx_e0", tx_a, 1);
    tick();
    check_eq("s_tx_e1", tx_a, 1);
    check_eq("s_full_e1", full_a, 0);
    ndone = 0; dpos = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      check_eq($sformatf("s_tx_c%0d", c), tx_a, exp_bit(8'h55, (c - 1) / 4));
      if (done_a) begin ndone++; dpos = c; end
      if (c == 1) check_eq("s_busy_c1", busy_a, 1);
    end
    check_eq("s_done_cnt", ndone, 1);
    check_eq("s_done_pos", dpos, 40);
    tick();
    check_eq("s_tx_after", tx_a, 1);
    check_eq("s_busy_after", busy_a, 0);

    // Back-to-back 0xA5 then 0x3C
    din_a = 8'hA5; wr_a = 1'b1;
    tick();
    wr_a = 1'b0;
    tick();
    ndone = 0; d1 = 0; d2 = 0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      wr_a = 1'b0;
      check_eq($sformatf("b2b_tx_c%0d", c), tx_a,
               exp_bit((c <= 40) ? 8'hA5 : 8'h3C, ((c - 1) % 40) / 4));
      if (done_a) begin
        ndone++;
        if (ndone == 1) d1 = c; else d2 = c;
      end
      if (c == 11 || c == 39) check_eq($sformatf("b2b_full_c%0d", c), full_a, 1);
      if (c == 41) check_eq("b2b_full_c41", full_a, 0);
      if (c == 10) begin din_a = 8'h3C; wr_a = 1'b1; end
    end
    check_eq("b2b_done_cnt", ndone, 2);
    check_eq("b2b_done1", d1, 40);
    check_eq("b2b_done2", d2, 80);
    tick();
    check_eq("b2b_tx_after", tx_a, 1);
    check_eq("b2b_busy_after", busy_a, 0);

    // Overrun: 0x11 in flight, 0x22 held, 0x33 and 0x44 dropped
    din_a = 8'h11; wr_a = 1'b1;
    tick();
    wr_a = 1'b0;
    tick();
    for (int c = 1; c <= 80; c++) begin
      tick();
      wr_a = 1'b0;
      clr_a = 1'b0;
      check_eq($sformatf("ovr_tx_c%0d", c), tx_a,
               exp_bit((c <= 40) ? 8'h11 : 8'h22, ((c - 1) % 40) / 4));
      if (c == 6) begin
        check_eq("ovr_full_held", full_a, 1);
        check_eq("ovr_clear_before", ovr_a, 0);
      end
      if (c == 8) begin
        check_eq("ovr_set", ovr_a, 1);
        check_eq("ovr_full_kept", full_a, 1);
      end
      if (c == 13) check_eq("ovr_cleared", ovr_a, 0);
      if (c == 21) check_eq("ovr_set_wins", ovr_a, 1);
      if (c == 25) check_eq("ovr_cleared2", ovr_a, 0);
      if (c == 5)  begin din_a = 8'h22; wr_a = 1'b1; end
      if (c == 7)  begin din_a = 8'h33; wr_a = 1'b1; end
      if (c == 12) clr_a = 1'b1;
      if (c == 20) begin din_a = 8'h44; wr_a = 1'b1; clr_a = 1'b1; end
      if (c == 24) clr_a = 1'b1;
    end
    tick();
    check_eq("ovr_tx_after", tx_a, 1);
    check_eq("ovr_busy_after", busy_a, 0);

    // Reset mid-frame during data bit 3 of 0xF0 with 0x0F held
    din_a = 8'hF0; wr_a = 1'b1;
    tick();
    wr_a = 1'b0;
    tick();
    for (int c = 1; c <= 18; c++) begin
      tick();
      wr_a = 1'b0;
      if (c == 2) begin din_a = 8'h0F; wr_a = 1'b1; end
    end
    check_eq("mid_tx_before", tx_a, 0);
    check_eq("mid_full_before", full_a, 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_tx_async", tx_a, 1);
    check_eq("mid_full_async", full_a, 0);
    check_eq("mid_busy_async", busy_a, 0);
    check_eq("mid_done_async", done_a, 0);
    tick();
    tick();
    reset = 1'b0;
    bad = 0; ndone = 0;
    repeat (60) begin
      tick();
      if (tx_a !== 1'b1) bad++;
      if (done_a) ndone++;
    end
    check_eq("mid_tx_low_after", bad, 0);
    check_eq("mid_done_after", ndone, 0);
    check_eq("mid_full_after", full_a, 0);

    // Two stop bits, byte 0xFF
    din_b = 8'hFF; wr_b = 1'b1;
    tick();
    wr_b = 1'b0;
    tick();
    ndone = 0; dpos = 0;
    for (int c = 1; c <= 44; c++) begin
      tick();
      check_eq($sformatf("s2_tx_c%0d", c), tx_b, exp_bit(8'hFF, (c - 1) / 4));
      if (done_b) begin ndone++; dpos = c; end
      if (c == 44) check_eq("s2_busy_c44", busy_b, 1);
    end
    check_eq("s2_done_cnt", ndone, 1);
    check_eq("s2_done_pos", dpos, 44);
    tick();
    check_eq("s2_busy_after", busy_b, 0);
    check_eq("s2_tx_after", tx_b, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
